// File: rtl/nios_system_leds_pkg.sv
// Shared constants for the LED PIO block: register addresses, STATUS bit
// positions and default sizing.
package nios_system_leds_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_PRESCALE_W = 24;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STAT_PHASE       = 0;
    localparam int STAT_PERIOD_ZERO = 1;

endpackage

// File: rtl/nios_system_leds_if.sv
// Avalon-MM slave bus for the LED PIO: word address, chip select, active-low
// write strobe, write data and registered read data.
interface nios_system_leds_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_system_leds_blink.sv
// Blink prescaler: phase toggles every `period` cycles; period 0 parks it low.
module nios_system_leds_blink #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PRESCALE_W-1:0] period,
    input  logic                  period_wr,
    output logic                  phase
);

    logic [PRESCALE_W-1:0] count;

    // A period write restarts the sequence and wins over a coincident wrap,
    // so a shortened period can never leave the counter past its terminal.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b0;
        end else if (period_wr || period == '0) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count == period - 1'b1) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/nios_system_leds.sv
// LED PIO with optional per-bit blink; optional OUTSET/OUTCLEAR registers are
// enabled by defining NIOS_SYSTEM_LEDS_BITSET_EN.
import nios_system_leds_pkg::*;

module nios_system_leds #(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_system_leds_if.slave   bus,
    output logic [WIDTH-1:0]    out_port
);

    logic [WIDTH-1:0]      data;
    logic [WIDTH-1:0]      mask;
    logic [PRESCALE_W-1:0] period;
    logic                  phase;
    logic                  wr_en;
    logic                  period_wr;
    logic [31:0]           rd_mux;
    logic                  unused_wd;

    assign wr_en     = bus.chipselect && !bus.write_n;
    assign period_wr = wr_en && (bus.address == ADDR_PERIOD);
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data   <= '0;
            mask   <= '0;
            period <= '0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data   <= bus.writedata[WIDTH-1:0];
                ADDR_MASK:     mask   <= bus.writedata[WIDTH-1:0];
                ADDR_PERIOD:   period <= bus.writedata[PRESCALE_W-1:0];
`ifdef NIOS_SYSTEM_LEDS_BITSET_EN
                ADDR_OUTSET:   data   <= data | bus.writedata[WIDTH-1:0];
                ADDR_OUTCLEAR: data   <= data & ~bus.writedata[WIDTH-1:0];
`endif
                default: ;
            endcase
        end
    end

    nios_system_leds_blink #(
        .PRESCALE_W (PRESCALE_W)
    ) u_blink (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period),
        .period_wr (period_wr),
        .phase     (phase)
    );

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux[WIDTH-1:0]      = data;
            ADDR_MASK:   rd_mux[WIDTH-1:0]      = mask;
            ADDR_PERIOD: rd_mux[PRESCALE_W-1:0] = period;
            ADDR_STATUS: begin
                rd_mux[STAT_PHASE]       = phase;
                rd_mux[STAT_PERIOD_ZERO] = (period == '0);
            end
            default: ;
        endcase
    end

    // Read data is sampled every cycle, independent of chipselect.
    always_ff @(posedge clk) begin
        if (!reset_n) bus.readdata <= '0;
        else          bus.readdata <= rd_mux;
    end

    assign out_port = data & ~(mask & {WIDTH{phase}});

endmodule

// File: tb/tb_nios_system_leds.sv
// Self-checking bench for nios_system_leds: directed scenarios plus random
// traffic against a time-based behavioural model of the LED block.
module tb_nios_system_leds;
    import nios_system_leds_pkg::*;

    localparam int W  = 8;
    localparam int PW = 24;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] out_port;

    nios_system_leds_if bus();

    nios_system_leds #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: registers plus cycles elapsed since the last period write.
    logic [W-1:0]  m_data = '0, m_mask = '0;
    logic [PW-1:0] m_period = '0;
    int            m_t = 0;
    logic [31:0]   exp_rd = '0;
    logic [W-1:0]  exp_out = '0;

`ifdef NIOS_SYSTEM_LEDS_BITSET_EN
    localparam logic [W-1:0] BITSET_DATA = 8'h3C;
`else
    localparam logic [W-1:0] BITSET_DATA = 8'h0F;
`endif

    function automatic logic m_phase();
        if (m_period == '0) return 1'b0;
        return ((m_t / int'(m_period)) % 2) == 1;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return 32'(m_data);
            3'd1:    return 32'(m_mask);
            3'd2:    return 32'(m_period);
            3'd3:    return {30'd0, m_period == '0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        @(posedge clk);
        if (!reset_n) begin
            m_data = '0; m_mask = '0; m_period = '0; m_t = 0; exp_rd = '0;
        end else begin
            exp_rd = m_read(a);
            m_t++;
            if (cs && !wn) begin
                case (a)
                    3'd0: m_data = wd[W-1:0];
                    3'd1: m_mask = wd[W-1:0];
                    3'd2: begin m_period = wd[PW-1:0]; m_t = 0; end
`ifdef NIOS_SYSTEM_LEDS_BITSET_EN
                    3'd4: m_data = m_data | wd[W-1:0];
                    3'd5: m_data = m_data & ~wd[W-1:0];
`endif
                    default: ;
                endcase
            end
        end
        exp_out = m_data & ~(m_mask & {W{m_phase()}});
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d); step(1'b1, 1'b0, a, d); endtask
    task automatic idle(input logic [2:0] a); step(1'b0, 1'b1, a, 32'hDEAD_BEEF); endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr(3'd0, 32'h55);
            checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out cyc%0d got=%h exp=00", i, out_port); end
            checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_rd cyc%0d got=%h exp=0", i, bus.readdata); end
        end
        reset_n = 1'b1;
        idle(3'd0);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL reset_data_rd got=%h exp=0", bus.readdata); end
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL reset_out_after got=%h exp=00", out_port); end
    endtask

    task automatic test_data();
        wr(3'd0, 32'hFFFF_FFA5);
        checks++; if (out_port !== 8'hA5) begin errors++; $display("FAIL data_out got=%h exp=a5", out_port); end
        idle(3'd0);
        checks++; if (bus.readdata !== 32'h0000_00A5) begin errors++; $display("FAIL data_rd got=%h exp=000000a5", bus.readdata); end
    endtask

    task automatic test_blink();
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        wr(3'd2, 32'd4);
        for (int i = 1; i <= 16; i++) begin
            idle(3'd3);
            checks++; if (out_port !== exp_out) begin errors++; $display("FAIL blink_out cyc%0d got=%h exp=%h", i, out_port, exp_out); end
            checks++; if (bus.readdata !== exp_rd) begin errors++; $display("FAIL blink_status cyc%0d got=%h exp=%h", i, bus.readdata, exp_rd); end
            if (i == 3) begin
                checks++; if (out_port !== 8'hFF) begin errors++; $display("FAIL blink_pre_toggle got=%h exp=ff", out_port); end
            end
            if (i == 4) begin
                checks++; if (out_port !== 8'hF0) begin errors++; $display("FAIL blink_first_toggle got=%h exp=f0", out_port); end
            end
        end
    endtask

    task automatic test_period_zero();
        for (int i = 0; i < 8 && !m_phase(); i++) idle(3'd3);
        checks++; if (out_port !== 8'hF0) begin errors++; $display("FAIL pz_phase_high got=%h exp=f0", out_port); end
        wr(3'd2, 32'd0);
        checks++; if (out_port !== 8'hFF) begin errors++; $display("FAIL pz_out got=%h exp=ff", out_port); end
        idle(3'd3);
        checks++; if (bus.readdata !== 32'h2) begin errors++; $display("FAIL pz_status got=%h exp=2", bus.readdata); end
    endtask

    task automatic test_bitset();
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
        wr(3'd5, 32'h03);
        idle(3'd0);
        checks++; if (bus.readdata !== 32'(BITSET_DATA)) begin errors++; $display("FAIL bitset_data got=%h exp=%h", bus.readdata, BITSET_DATA); end
        idle(3'd4);
        checks++; if (bus.readdata !== 32'h0) begin errors++; $display("FAIL bitset_addr4_rd got=%h exp=0", bus.readdata); end
    endtask

    task automatic test_unmapped();
        logic [2:0]  addrs [5];
        logic [31:0] want  [5];
        addrs = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd3};
        want  = '{32'(BITSET_DATA), 32'h0F, 32'h0, 32'h0, 32'h2};
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd7, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            idle(addrs[i]);
            checks++; if (bus.readdata !== want[i]) begin errors++; $display("FAIL unmapped_rd addr%0d got=%h exp=%h", addrs[i], bus.readdata, want[i]); end
        end
        checks++; if (out_port !== BITSET_DATA) begin errors++; $display("FAIL unmapped_out got=%h exp=%h", out_port, BITSET_DATA); end
    endtask

    task automatic test_reset_midblink();
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'd3);
        for (int i = 0; i < 5; i++) idle(3'd3);
        reset_n = 1'b0;
        idle(3'd3);
        idle(3'd3);
        checks++; if (out_port !== 8'h00) begin errors++; $display("FAIL midblink_reset_out got=%h exp=00", out_port); end
        reset_n = 1'b1;
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'hFF);
        for (int i = 0; i < 10; i++) begin
            idle(3'd3);
            checks++; if (out_port !== 8'hFF) begin errors++; $display("FAIL midblink_noblink cyc%0d got=%h exp=ff", i, out_port); end
        end
        checks++; if (bus.readdata !== 32'h2) begin errors++; $display("FAIL midblink_status got=%h exp=2", bus.readdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic        cs, wn;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            cs = $urandom_range(0, 3) != 0;
            wn = $urandom_range(0, 1) == 1;
            wd = (a == 3'd2) ? 32'($urandom_range(0, 9)) : $urandom;
            reset_n = ($urandom_range(0, 59) != 0);
            step(cs, wn, a, wd);
            checks++; if (out_port !== exp_out) begin errors++; $display("FAIL rand_out it%0d got=%h exp=%h", i, out_port, exp_out); end
            checks++; if (bus.readdata !== exp_rd) begin errors++; $display("FAIL rand_rd it%0d got=%h exp=%h", i, bus.readdata, exp_rd); end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'd0;
        test_reset();
        test_data();
        test_blink();
        test_period_zero();
        test_bitset();
        test_unmapped();
        test_reset_midblink();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nios_system_leds.md
NIOS_SYSTEM_LEDS -- requirements
Module: nios_system_leds

Interface
REQ-001 Parameter WIDTH, default 8: output port width in bits (1..32).
REQ-002 Parameter PRESCALE_W, default 24: width of the blink period register and counter.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  write strobe, active-low.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  registered read data.
REQ-010 out_port  output  WIDTH  LED drive.

Function
REQ-011 The block SHALL accept a write on a cycle where chipselect=1 and write_n=0, with zero wait states.
REQ-012 Register map SHALL be:
- 0 DATA (RW, WIDTH bits)
- 1 BLINK_MASK (RW, WIDTH bits)
- 2 BLINK_PERIOD (RW, PRESCALE_W bits)
- 3 STATUS (RO; bit0 = phase, bit1 = period==0)
- 4 OUTSET / 5 OUTCLEAR (see Configuration)
- 6-7 unmapped.
REQ-013 Write bits above a register's width SHALL be ignored; writes to STATUS and to unmapped addresses SHALL have no effect.
REQ-014 readdata SHALL update every cycle, regardless of chipselect, with the zero-extended value selected by address, giving 1-cycle read latency.
REQ-015 Unmapped, OUTSET and OUTCLEAR addresses SHALL read 0.
REQ-016 DATA SHALL read back the stored data register, not out_port.
REQ-017 Blink counter behaviour SHALL be:
- BLINK_PERIOD=0: counter held 0, phase held 0.
- Otherwise: counter increments each cycle.
- On counter==BLINK_PERIOD-1: counter returns to 0 and phase toggles, i.e. phase half-period = BLINK_PERIOD cycles.
REQ-018 A write to BLINK_PERIOD SHALL clear the counter and phase on the same edge; this write takes priority over a coincident wrap.
REQ-019 Lowering BLINK_PERIOD below the current count SHALL NOT cause counter overrun, because REQ-018 clears the counter.
REQ-020 out_port SHALL equal DATA & ~(BLINK_MASK & {WIDTH{phase}}), driven from registers only, and reflect a write on the cycle after the write edge.
REQ-021 Writes to DATA or BLINK_MASK SHALL NOT disturb the counter or phase.

Reset
REQ-022 While reset_n=0 at a clk edge, the following SHALL all load 0: DATA, BLINK_MASK, BLINK_PERIOD, counter, phase, readdata; out_port SHALL therefore be 0.
REQ-023 Reset asserted mid-blink SHALL abort the sequence; after release, blinking stays off until BLINK_PERIOD is rewritten.
REQ-024 A write presented while reset_n=0 SHALL be discarded.

Configuration
REQ-025 Macro NIOS_SYSTEM_LEDS_BITSET_EN SHALL control the bit set/clear registers.
REQ-026 With NIOS_SYSTEM_LEDS_BITSET_EN defined:
- write to address 4 (OUTSET): DATA <= DATA | writedata[WIDTH-1:0].
- write to address 5 (OUTCLEAR): DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-027 With NIOS_SYSTEM_LEDS_BITSET_EN undefined, addresses 4-5 SHALL behave as unmapped.

Structure
REQ-028 Package nios_system_leds_pkg SHALL hold:
- address constants ADDR_DATA..ADDR_OUTCLEAR
- STATUS bit indices
- default WIDTH and PRESCALE_W.
REQ-029 Counter and phase SHALL reside in sub-module nios_system_leds_blink, with these ports:
- inputs: clk, reset_n, period, period_wr
- output: phase.
REQ-030 The top level SHALL contain the register file, read mux and out_port logic.

Verification
REQ-031 Reset: hold reset_n=0 for 3 cycles with a write to DATA pending -> out_port=0x00, readdata=0, DATA reads 0 after release.
REQ-032 Write DATA=0xA5, then read address 0 -> out_port=0xA5 on the next cycle; readdata=0x000000A5 one cycle after address is presented.
REQ-033 DATA=0xFF, BLINK_MASK=0x0F, BLINK_PERIOD=4 -> out_port alternates between 0xFF and 0xF0 every 4 cycles, first toggle 4 cycles after the period write; STATUS bit0 tracks phase.
REQ-034 Rewrite BLINK_PERIOD=0 while phase=1 -> phase=0, out_port=0xFF next cycle, STATUS=0x2.
REQ-035 With NIOS_SYSTEM_LEDS_BITSET_EN, DATA=0x0F, OUTSET=0x30, then OUTCLEAR=0x03 -> DATA reads 0x3C; address 4 reads 0. Without the macro, the same writes leave DATA=0x0F.
REQ-036 Write 0xFFFFFFFF to STATUS and to address 7 -> no register changes; both addresses read per REQ-012 and REQ-015.
